alu_result_serializer: RTL
==========================

Name: alu_result_serializer

Overview:
Parallel-to-serial transmitter for the 8-bit ALU datapath. It takes a WIDTH-bit word from a parallel result register through a valid/ready load handshake, then shifts it out one bit at a time. Each bit is held for a programmable number of clock cycles, and framing strobes mark the start and end of each word. It sits downstream of the result register and drives the serial link, debug pin or test bus.

Parameters:
WIDTH, 8, data word width in bits; must be at least 2.
BIT_CYCLES, 1, clock cycles each bit is held on ser_out; must be at least 1.
LSB_FIRST, 1, 1 shifts bit 0 first, 0 shifts bit WIDTH-1 first.

Ports:
clk  input  1  system clock; all logic updates on the rising edge.
rst  input  1  synchronous, active-high reset.
load_valid  input  1  load_data is valid this cycle.
load_data  input  WIDTH  parallel word to transmit.
load_ready  output  1  serializer can accept a word this cycle.
ser_out  output  1  serial data bit.
ser_valid  output  1  ser_out carries a frame bit.
frame_start  output  1  one-cycle pulse on the first cycle of the first bit.
frame_done  output  1  one-cycle pulse on the last cycle of the last bit.
busy  output  1  a frame is in progress.

Behaviour:
- Interface:
  - One clock, clk.
  - Reset rst is synchronous and active-high.
  - All outputs are registered.
- Reset values:
  - load_ready=1.
  - ser_out=0, ser_valid=0, frame_start=0, frame_done=0, busy=0.
  - State=IDLE; shift register, bit counter and cycle counter all cleared.
- States: IDLE and SHIFT.
- Accept:
  - A word is accepted on a rising edge where load_valid and load_ready are both 1.
  - load_data is captured into the internal shift register on that edge.
  - From the next cycle: state=SHIFT, busy=1, ser_valid=1, ser_out=first bit, frame_start=1 for exactly one cycle.
- Latency: 1 clock from the accept edge to the first bit on ser_out.
- Bit timing:
  - The cycle counter counts 0..BIT_CYCLES-1 for each bit.
  - On wrap, the bit counter increments and the shift register advances one bit in the LSB_FIRST direction.
  - Frame length is WIDTH*BIT_CYCLES cycles.
- load_ready while shifting:
  - load_ready=0 during SHIFT, except on the final cycle of the final bit, where load_ready=1.
  - frame_done=1 on that same final cycle.
- Back-to-back frames:
  - If a word is accepted on the final cycle, the next cycle starts the new frame directly.
  - The new frame starts with frame_start=1, no idle gap, and ser_valid stays at 1.
- End of frame with no new word: the next cycle returns to IDLE (ser_valid=0, ser_out=0, busy=0, load_ready=1).
- ser_out is forced to 0 whenever ser_valid=0.
- load_valid and load_data are ignored whenever load_ready=0; a word already in flight is never corrupted.
- Reset mid-frame:
  - The frame is aborted; frame_done is not pulsed.
  - All outputs take their reset values on the cycle after the rst edge.
  - rst has priority over a simultaneous accept.
- Counter widths: the bit counter is clog2(WIDTH+1) bits, the cycle counter is clog2(BIT_CYCLES) bits (minimum 1). Neither counter may wrap outside its defined range.

Optional Feature:
Macro SERIALIZER_PARITY_EN.
- Defined:
  - An even-parity bit (XOR of all captured data bits) is appended after the last data bit.
  - The parity bit is held for BIT_CYCLES cycles with ser_valid=1.
  - Frame length becomes (WIDTH+1)*BIT_CYCLES.
  - frame_done and the early load_ready move to the last cycle of the parity bit.
  - Parity is computed from the word as captured, not from live load_data.
- Undefined:
  - No parity logic is present.
  - Frame is exactly WIDTH bits, as above.

Test Plan:
- WIDTH=8, BIT_CYCLES=1, LSB_FIRST=1; accept 0xA5 at cycle 0:
  - ser_out on cycles 1..8 is 1,0,1,0,0,1,0,1.
  - frame_start at cycle 1; frame_done and load_ready at cycle 8; ser_valid=0 at cycle 9.
- LSB_FIRST=0, BIT_CYCLES=3; accept 0x81:
  - ser_out is 1 for 3 cycles, then 0 for 18 cycles, then 1 for 3 cycles (24 ser_valid cycles in total).
  - frame_done on the 24th cycle.
- Back-to-back: accept 0x0F, hold load_valid with 0xF0:
  - 0xF0 is accepted on the final cycle of 0x0F.
  - 16 contiguous ser_valid cycles; frame_start pulses on cycles 1 and 9; output is 1,1,1,1,0,0,0,0,0,0,0,0,1,1,1,1.
- Busy ignore: accept 0x00, then drive load_valid=1 with 0xFF during the frame:
  - All 8 bits of the first frame are 0.
  - 0xFF is accepted only when load_ready=1.
- Reset mid-frame: assert rst during bit 3 of 0x3C:
  - Next cycle all outputs are at reset values; no frame_done pulse.
  - A subsequent accept of 0x3C transmits 0,0,1,1,1,1,0,0 (LSB first).
- SERIALIZER_PARITY_EN defined; accept 0x07 (BIT_CYCLES=1):
  - 9 bits out: 1,1,1,0,0,0,0,0,1.
  - frame_done on cycle 9; accept 0x03 gives parity bit 0.

Source files
------------

// File: rtl/alu_result_serializer.sv
// Parallel-to-serial transmitter with valid/ready load, per-bit hold time and framing strobes.
// Optional even-parity trailer bit when SERIALIZER_PARITY_EN is defined.
module alu_result_serializer #(
  parameter int unsigned WIDTH      = 8,
  parameter int unsigned BIT_CYCLES = 1,
  parameter bit          LSB_FIRST  = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load_valid,
  input  logic [WIDTH-1:0] load_data,
  output logic             load_ready,
  output logic             ser_out,
  output logic             ser_valid,
  output logic             frame_start,
  output logic             frame_done,
  output logic             busy
);

`ifdef SERIALIZER_PARITY_EN
  localparam int unsigned NumBits = WIDTH + 1;
`else
  localparam int unsigned NumBits = WIDTH;
`endif
  localparam int unsigned BitW = $clog2(WIDTH + 1);
  localparam int unsigned CycW = (BIT_CYCLES > 1) ? $clog2(BIT_CYCLES) : 1;
  localparam logic [BitW-1:0] BitLast = BitW'(NumBits - 1);
  localparam logic [CycW-1:0] CycLast = CycW'(BIT_CYCLES - 1);

  typedef enum logic [0:0] {StIdle, StShift} state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] shreg_q, shreg_d;
  logic [BitW-1:0]  bit_cnt_q, bit_cnt_d;
  logic [CycW-1:0]  cyc_cnt_q, cyc_cnt_d;
  logic             load_ready_q, load_ready_d;
  logic             ser_out_q, ser_out_d;
  logic             ser_valid_q, ser_valid_d;
  logic             frame_start_q, frame_start_d;
  logic             frame_done_q, frame_done_d;
  logic             busy_q, busy_d;
  logic             accept;
  logic             last_d;
  logic             head_bit;
`ifdef SERIALIZER_PARITY_EN
  logic             parity_q, parity_d;
`endif

  // load_ready is a registered output, so it gates acceptance directly.
  assign accept = load_valid & load_ready_q;

  always_comb begin
    state_d   = state_q;
    shreg_d   = shreg_q;
    bit_cnt_d = bit_cnt_q;
    cyc_cnt_d = cyc_cnt_q;
`ifdef SERIALIZER_PARITY_EN
    parity_d  = parity_q;
`endif
    if (accept) begin
      state_d   = StShift;
      shreg_d   = load_data;
      bit_cnt_d = '0;
      cyc_cnt_d = '0;
`ifdef SERIALIZER_PARITY_EN
      parity_d  = ^load_data;
`endif
    end else if (state_q == StShift) begin
      if (cyc_cnt_q == CycLast) begin
        cyc_cnt_d = '0;
        if (bit_cnt_q == BitLast) begin
          state_d   = StIdle;
          bit_cnt_d = '0;
          shreg_d   = '0;
        end else begin
          bit_cnt_d = bit_cnt_q + 1'b1;
          shreg_d   = LSB_FIRST ? (shreg_q >> 1) : (shreg_q << 1);
        end
      end else begin
        cyc_cnt_d = cyc_cnt_q + 1'b1;
      end
    end

    // Outputs are derived from next-state so that every output is a flop.
    head_bit      = LSB_FIRST ? shreg_d[0] : shreg_d[WIDTH-1];
`ifdef SERIALIZER_PARITY_EN
    if (bit_cnt_d == BitW'(WIDTH)) begin
      head_bit = parity_d;
    end
`endif
    last_d        = (state_d == StShift) && (bit_cnt_d == BitLast) && (cyc_cnt_d == CycLast);
    ser_valid_d   = (state_d == StShift);
    busy_d        = (state_d == StShift);
    ser_out_d     = ser_valid_d & head_bit;
    frame_start_d = accept;
    frame_done_d  = last_d;
    load_ready_d  = (state_d == StIdle) || last_d;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= StIdle;
      shreg_q       <= '0;
      bit_cnt_q     <= '0;
      cyc_cnt_q     <= '0;
      load_ready_q  <= 1'b1;
      ser_out_q     <= 1'b0;
      ser_valid_q   <= 1'b0;
      frame_start_q <= 1'b0;
      frame_done_q  <= 1'b0;
      busy_q        <= 1'b0;
`ifdef SERIALIZER_PARITY_EN
      parity_q      <= 1'b0;
`endif
    end else begin
      state_q       <= state_d;
      shreg_q       <= shreg_d;
      bit_cnt_q     <= bit_cnt_d;
      cyc_cnt_q     <= cyc_cnt_d;
      load_ready_q  <= load_ready_d;
      ser_out_q     <= ser_out_d;
      ser_valid_q   <= ser_valid_d;
      frame_start_q <= frame_start_d;
      frame_done_q  <= frame_done_d;
      busy_q        <= busy_d;
`ifdef SERIALIZER_PARITY_EN
      parity_q      <= parity_d;
`endif
    end
  end

  assign load_ready  = load_ready_q;
  assign ser_out     = ser_out_q;
  assign ser_valid   = ser_valid_q;
  assign frame_start = frame_start_q;
  assign frame_done  = frame_done_q;
  assign busy        = busy_q;

endmodule
